// File: rtl/debounce_pkg.sv
// Shared defaults and the counter-width helper for the multi-channel button debouncer.
package debounce_pkg;

    localparam int unsigned NCH_MAX        = 16;
    localparam int unsigned STABLE_CNT_DEF = 500000;
    localparam int unsigned REPEAT_DLY_DEF = 50000000;
    localparam int unsigned REPEAT_PER_DEF = 10000000;

    // One spare bit above the largest terminal count so no counter can wrap.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single button channel: 2-flop sync, stability counter, level, edge pulses, optional auto-repeat.
// Auto-repeat timer is built only when DEBOUNCE_REPEAT_EN is defined.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = STABLE_CNT_DEF,
    parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
    parameter int unsigned REPEAT_PER = REPEAT_PER_DEF
) (
    input  logic clk,
    input  logic reset2,
    input  logic btn_raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic rpt
);

    localparam int unsigned CW = cnt_width(STABLE_CNT, REPEAT_DLY, REPEAT_PER);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] stab_cnt;
    logic [CW-1:0] stab_cnt_nxt;
    logic          level_nxt;

    always_ff @(posedge clk or posedge reset2) begin
        if (reset2) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_comb begin
        stab_cnt_nxt = '0;
        level_nxt    = level;
        if (sync_q2 != level) begin
            if (stab_cnt == CW'(STABLE_CNT - 1)) begin
                level_nxt = sync_q2;
            end else begin
                stab_cnt_nxt = stab_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset2) begin
        if (reset2) begin
            stab_cnt <= '0;
            level    <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            stab_cnt <= stab_cnt_nxt;
            level    <= level_nxt;
            rise     <= level_nxt & ~level;
            fall     <= ~level_nxt & level;
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    logic [CW-1:0] rep_cnt;
    logic [CW-1:0] rep_cnt_nxt;
    logic [CW-1:0] rep_inc;
    logic [CW-1:0] rep_tgt;
    logic          rep_first;
    logic          rep_first_nxt;
    logic          rpt_nxt;

    // Timer runs only while the level stays high; first interval is the delay, then the period.
    always_comb begin
        rep_cnt_nxt   = '0;
        rep_first_nxt = 1'b1;
        rpt_nxt       = 1'b0;
        rep_inc       = rep_cnt + CW'(1);
        rep_tgt       = rep_first ? CW'(REPEAT_DLY) : CW'(REPEAT_PER);
        if (level && level_nxt) begin
            if (rep_inc == rep_tgt) begin
                rpt_nxt       = 1'b1;
                rep_first_nxt = 1'b0;
            end else begin
                rep_cnt_nxt   = rep_inc;
                rep_first_nxt = rep_first;
            end
        end
    end

    always_ff @(posedge clk or posedge reset2) begin
        if (reset2) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
            rpt       <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_nxt;
            rep_first <= rep_first_nxt;
            rpt       <= rpt_nxt;
        end
    end
`else
    assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debouncer_multi.sv
// NCH independent debounced button channels with press/release pulses and auto-repeat.
// Define DEBOUNCE_REPEAT_EN to build the auto-repeat timers; otherwise btn_repeat is 0.
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int unsigned NCH        = 4,
    parameter int unsigned STABLE_CNT = STABLE_CNT_DEF,
    parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
    parameter int unsigned REPEAT_PER = REPEAT_PER_DEF
) (
    input  logic           clk,
    input  logic           reset2,
    input  logic [NCH-1:0] btn_in,
    output logic [NCH-1:0] btn_level,
    output logic [NCH-1:0] btn_rise,
    output logic [NCH-1:0] btn_fall,
    output logic [NCH-1:0] btn_repeat
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CNT (STABLE_CNT),
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
        ) u_chan (
            .clk     (clk),
            .reset2  (reset2),
            .btn_raw (btn_in[i]),
            .level   (btn_level[i]),
            .rise    (btn_rise[i]),
            .fall    (btn_fall[i]),
            .rpt     (btn_repeat[i])
        );
    end

endmodule

// File: doc/debouncer_multi.md
DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 Parameter NCH, default 4: number of independent button channels, 1..16.
REQ-002 Parameter STABLE_CNT, default 500000: consecutive synchronized cycles a changed input must hold before it is accepted, minimum 2.
REQ-003 Parameter REPEAT_DLY, default 50000000: cycles from accepted press to the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PER, default 10000000: cycles between subsequent auto-repeat pulses.
REQ-005 clk  input  1  single clock; all state SHALL be on its rising edge.
REQ-006 reset2  input  1  asynchronous, active-high reset.
REQ-007 btn_in  input  NCH  raw, asynchronous, bouncing button levels.
REQ-008 btn_level  output  NCH  debounced level, registered.
REQ-009 btn_rise  output  NCH  one-cycle pulse on accepted press.
REQ-010 btn_fall  output  NCH  one-cycle pulse on accepted release.
REQ-011 btn_repeat  output  NCH  one-cycle auto-repeat pulses while held.

Function
REQ-012 Each channel SHALL pass btn_in[i] through a 2-flop synchronizer before any other logic.
REQ-013 Per-channel counter SHALL increment each cycle the synchronized input differs from btn_level[i], and SHALL clear to 0 on any cycle they agree.
REQ-014 When the counter reaches STABLE_CNT-1 while still differing, btn_level[i] SHALL take the synchronized value on the next edge and the counter SHALL clear.
REQ-015 Latency from a clean btn_in edge to btn_level change SHALL be exactly 2+STABLE_CNT cycles.
REQ-016 Any bounce shorter than STABLE_CNT synchronized cycles SHALL produce no output change and SHALL restart the count.
REQ-017 btn_rise[i] (btn_fall[i]) SHALL be high exactly in the first cycle btn_level[i] reads 1 (0), registered, never two consecutive cycles.
REQ-018 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-019 Counter width SHALL be $clog2 of the largest of STABLE_CNT, REPEAT_DLY, REPEAT_PER, plus 1; counters SHALL never wrap.

Reset
REQ-020 reset2 high SHALL immediately clear synchronizers, counters, repeat timers and all outputs to 0.
REQ-021 A button held through reset SHALL be accepted as a new press 2+STABLE_CNT cycles after reset2 falls, with a btn_rise pulse.
REQ-022 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL result from it.

Configuration
REQ-023 Macro DEBOUNCE_REPEAT_EN defined: per-channel repeat timer SHALL start at 0 on btn_rise, pulse btn_repeat[i] when it reaches REPEAT_DLY, then every REPEAT_PER cycles while btn_level[i]=1, and clear on btn_level[i]=0.
REQ-024 Macro undefined: repeat timers SHALL not be built, btn_repeat SHALL be constant 0, port list unchanged.

Structure
REQ-025 Package debounce_pkg SHALL hold default constants (STABLE_CNT, REPEAT_DLY, REPEAT_PER defaults, NCH_MAX=16) and the counter-width function.
REQ-026 One sub-module debounce_chan SHALL implement a single channel (sync, counter, level, edge pulses, optional repeat), instantiated NCH times via generate.

Verification (bench: NCH=4, STABLE_CNT=8, REPEAT_DLY=20, REPEAT_PER=5)
REQ-027 reset2=1 with btn_in=4'hF -> all outputs 0; reset2 falls -> btn_level=4'hF after 10 cycles, btn_rise=4'hF for exactly one cycle.
REQ-028 ch0 toggled every 3 cycles for 40 cycles then held 1 -> btn_level[0] stays 0 during bounce, rises 10 cycles after final edge, single btn_rise[0].
REQ-029 ch1 pulsed high for 7 cycles -> no change on any output; pulsed for 8 cycles -> btn_level[1]=1 with btn_rise[1].
REQ-030 ch2 press accepted then btn_in[2]=0 -> btn_fall[2] one cycle, btn_level[2]=0, 10 cycles after release edge.
REQ-031 ch3 held 50 cycles past btn_rise, macro defined -> btn_repeat[3] pulses at +20,+25,+30,+35,+40,+45,+50; macro undefined -> btn_repeat stays 0.
REQ-032 reset2 pulsed while ch0 counter=5 -> counter cleared, no pulse; btn_in held 1 -> btn_rise[0] 10 cycles after reset2 falls.
